// File: rtl/arm_cmd_receiver.sv
// Receive-side decoder for the 5-bit FPGA-to-arm command bus: synchronizes and
// debounces the strobe, validates the one-hot code, tracks protocol order, hands commands off.
module arm_cmd_receiver #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic [4:0] sig_in,
    input  logic       cmd_ready,
    input  logic       err_clear,
    output logic       cmd_valid,
    output logic [1:0] cmd,
    output logic [3:0] cmd_onehot,
    output logic       bad_code,
    output logic       overrun,
    output logic       seq_error,
    output logic [7:0] err_count,
    output logic [1:0] phase
);

    localparam logic [7:0] C_DEB = 8'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {S_DISARMED, S_ARMED, S_RISE_CNT} state_t;

    logic [4:0] r_sync1, r_sync2;
    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_qualify;

    logic       r_cmd_valid;
    logic [1:0] r_cmd;
    logic [3:0] r_cmd_onehot;
    logic       r_bad_code;
    logic       r_overrun;
    logic       r_seq_error;
    logic [7:0] r_err_count;
    logic [1:0] r_phase;

    logic       w_strobe;
    logic [3:0] w_code;
    logic [7:0] w_cnt_inc;
    logic       w_onehot;
    logic [1:0] w_enc;
    logic       w_can_load;
    logic       w_load;
    logic       w_bad;
    logic       w_ovr;
    logic       w_seq_err;
    logic       w_err_evt;

    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_strobe  = r_sync2[0];
    assign w_code    = r_sync2[4:1];
    assign w_cnt_inc = r_cnt + 8'd1;

    // Strobe debounce: must see DEBOUNCE_CYCLES lows to arm, then DEBOUNCE_CYCLES highs to qualify.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_state   <= S_DISARMED;
            r_cnt     <= '0;
            r_qualify <= 1'b0;
        end else begin
            r_qualify <= 1'b0;
            case (r_state)
                S_DISARMED: begin
                    if (w_strobe) begin
                        r_cnt <= '0;
                    end else if (w_cnt_inc == C_DEB) begin
                        r_state <= S_ARMED;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_ARMED: begin
                    if (w_strobe) begin
                        if (C_DEB == 8'd1) begin
                            r_qualify <= 1'b1;
                            r_state   <= S_DISARMED;
                            r_cnt     <= '0;
                        end else begin
                            r_state <= S_RISE_CNT;
                            r_cnt   <= 8'd1;
                        end
                    end
                end
                S_RISE_CNT: begin
                    if (!w_strobe) begin
                        r_state <= S_ARMED;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc == C_DEB) begin
                        r_qualify <= 1'b1;
                        r_state   <= S_DISARMED;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= S_DISARMED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_onehot = (w_code != 4'd0) && ((w_code & (w_code - 4'd1)) == 4'd0);

    always_comb begin
        w_enc = 2'd0;
        case (w_code)
            4'b1000: w_enc = 2'd1;
            4'b0100: w_enc = 2'd2;
            4'b0001: w_enc = 2'd3;
            default: w_enc = 2'd0;
        endcase
    end

    // A handshake completing this cycle frees the slot for a new command.
    assign w_can_load = !r_cmd_valid || cmd_ready;
    assign w_load     = r_qualify && w_onehot && w_can_load;
    assign w_bad      = r_qualify && !w_onehot;
    assign w_ovr      = r_qualify && w_onehot && !w_can_load;
    assign w_seq_err  = w_load && (w_enc != 2'd0) && (w_enc != r_phase);
    assign w_err_evt  = w_bad || w_ovr || w_seq_err;

    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_cmd_valid  <= 1'b0;
            r_cmd        <= '0;
            r_cmd_onehot <= '0;
            r_bad_code   <= 1'b0;
            r_overrun    <= 1'b0;
            r_seq_error  <= 1'b0;
            r_err_count  <= '0;
            r_phase      <= '0;
        end else begin
            r_bad_code <= w_bad;

            if (w_load) begin
                r_cmd_valid  <= 1'b1;
                r_cmd        <= w_enc;
                r_cmd_onehot <= w_code;
                r_phase      <= w_enc + 2'd1;
            end else if (r_cmd_valid && cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end

            if (w_ovr) begin
                r_overrun <= 1'b1;
            end else if (err_clear) begin
                r_overrun <= 1'b0;
            end

            if (w_seq_err) begin
                r_seq_error <= 1'b1;
            end else if (err_clear) begin
                r_seq_error <= 1'b0;
            end

            // An error event coinciding with a clear restarts the count at one.
            if (w_err_evt) begin
                if (err_clear) begin
                    r_err_count <= 8'd1;
                end else if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end else if (err_clear) begin
                r_err_count <= '0;
            end
        end
    end

    assign cmd_valid  = r_cmd_valid;
    assign cmd        = r_cmd;
    assign cmd_onehot = r_cmd_onehot;
    assign bad_code   = r_bad_code;
    assign overrun    = r_overrun;
    assign seq_error  = r_seq_error;
    assign err_count  = r_err_count;
    assign phase      = r_phase;

endmodule

// File: tb/tb_arm_cmd_receiver.sv
// Directed bench for arm_cmd_receiver: latency, debounce, error flags, handshake and reset.
module tb_arm_cmd_receiver;

    logic       clock_50 = 1'b0;
    logic       reset;
    logic [4:0] sig_in;
    logic       cmd_ready;
    logic       err_clear;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [3:0] cmd_onehot;
    logic       bad_code;
    logic       overrun;
    logic       seq_error;
    logic [7:0] err_count;
    logic [1:0] phase;

    int n_checks = 0;
    int n_errors = 0;
    int hs_count = 0;
    int bad_cycles = 0;
    logic [1:0] last_cmd = 2'd0;
    int exp_hs = 0;
    int exp_bad = 0;

    arm_cmd_receiver #(.DEBOUNCE_CYCLES(16)) dut (
        .clock_50   (clock_50),
        .reset      (reset),
        .sig_in     (sig_in),
        .cmd_ready  (cmd_ready),
        .err_clear  (err_clear),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .cmd_onehot (cmd_onehot),
        .bad_code   (bad_code),
        .overrun    (overrun),
        .seq_error  (seq_error),
        .err_count  (err_count),
        .phase      (phase)
    );

    always #5 clock_50 = ~clock_50;

    // Observed handshakes and bad_code pulse cycles.
    always @(posedge clock_50) begin
        if (cmd_valid && cmd_ready) begin
            hs_count <= hs_count + 1;
            last_cmd <= cmd;
        end
        if (bad_code) bad_cycles <= bad_cycles + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock_50);
        #1;
    endtask

    task automatic send(input logic [4:0] code);
        sig_in = code;
        repeat (24) tick();
        sig_in = 5'b00000;
        repeat (20) tick();
    endtask

    initial begin
        reset = 1'b1; sig_in = 5'b0; cmd_ready = 1'b1; err_clear = 1'b0;
        repeat (3) tick();
        chk("rst_valid", cmd_valid, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_onehot", cmd_onehot, 0);
        chk("rst_bad", bad_code, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_seq", seq_error, 0);
        chk("rst_errcnt", err_count, 0);
        chk("rst_phase", phase, 0);
        reset = 1'b0;
        repeat (20) tick();

        // Nominal latency: e0 is the first edge after the drive.
        sig_in = 5'b00101;
        repeat (18) tick();
        chk("lat_e17_valid", cmd_valid, 0);
        tick();
        chk("lat_e18_valid", cmd_valid, 1);
        chk("lat_cmd", cmd, 0);
        chk("lat_onehot", cmd_onehot, 4'b0010);
        chk("lat_phase", phase, 1);
        tick();
        chk("lat_e19_valid", cmd_valid, 0);
        exp_hs++;
        repeat (5) tick();
        sig_in = 5'b0;
        repeat (20) tick();

        send(5'b10001); exp_hs++;
        chk("nom_search_hs", hs_count, exp_hs);
        chk("nom_search_cmd", last_cmd, 1);
        chk("nom_search_phase", phase, 2);
        send(5'b01001); exp_hs++;
        chk("nom_place_hs", hs_count, exp_hs);
        chk("nom_place_cmd", last_cmd, 2);
        chk("nom_place_phase", phase, 3);
        send(5'b00011); exp_hs++;
        chk("nom_stop_hs", hs_count, exp_hs);
        chk("nom_stop_cmd", last_cmd, 3);
        chk("nom_stop_phase", phase, 0);
        chk("nom_seq", seq_error, 0);
        chk("nom_errcnt", err_count, 0);

        // Glitch: 15-cycle pulse must not qualify; the following long pulse fires once.
        sig_in = 5'b00101;
        repeat (15) tick();
        sig_in = 5'b00100;
        repeat (3) tick();
        chk("glitch_none", hs_count, exp_hs);
        sig_in = 5'b00101;
        repeat (40) tick();
        sig_in = 5'b0;
        repeat (20) tick();
        exp_hs++;
        chk("glitch_one", hs_count, exp_hs);
        chk("glitch_phase", phase, 1);

        // Bad code.
        send(5'b11001); exp_bad++;
        chk("bad_pulses", bad_cycles, exp_bad);
        chk("bad_errcnt", err_count, 1);
        chk("bad_no_hs", hs_count, exp_hs);
        chk("bad_valid", cmd_valid, 0);
        chk("bad_phase", phase, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("clr_errcnt", err_count, 0);

        // Overrun with executor stalled.
        cmd_ready = 1'b0;
        send(5'b10001);
        chk("ovr_valid1", cmd_valid, 1);
        chk("ovr_cmd1", cmd, 1);
        chk("ovr_phase1", phase, 2);
        send(5'b01001);
        chk("ovr_flag", overrun, 1);
        chk("ovr_errcnt", err_count, 1);
        chk("ovr_cmd_kept", cmd, 1);
        chk("ovr_phase_kept", phase, 2);
        cmd_ready = 1'b1;
        tick();
        tick();
        exp_hs++;
        chk("ovr_valid_fall", cmd_valid, 0);
        chk("ovr_hs", hs_count, exp_hs);
        chk("ovr_hs_cmd", last_cmd, 1);

        // Sequence error after reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (20) tick();
        send(5'b01001); exp_hs++;
        chk("seq_hs", hs_count, exp_hs);
        chk("seq_cmd", last_cmd, 2);
        chk("seq_flag", seq_error, 1);
        chk("seq_phase", phase, 3);
        chk("seq_errcnt", err_count, 1);
        send(5'b00101); exp_hs++;
        chk("resync_cmd", last_cmd, 0);
        chk("resync_errcnt", err_count, 1);
        chk("resync_phase", phase, 1);

        // Reset mid-operation with strobe high and command pending.
        cmd_ready = 1'b0;
        sig_in = 5'b10001;
        repeat (25) tick();
        chk("mid_pending", cmd_valid, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", cmd_valid, 0);
        chk("mid_rst_cmd", cmd, 0);
        chk("mid_rst_onehot", cmd_onehot, 0);
        chk("mid_rst_seq", seq_error, 0);
        chk("mid_rst_errcnt", err_count, 0);
        chk("mid_rst_phase", phase, 0);
        reset = 1'b0;
        cmd_ready = 1'b1;
        repeat (40) tick();
        chk("mid_held_valid", cmd_valid, 0);
        chk("mid_held_hs", hs_count, exp_hs);
        sig_in = 5'b0;
        repeat (20) tick();
        send(5'b10001); exp_hs++;
        chk("mid_rearm_hs", hs_count, exp_hs);
        chk("mid_rearm_cmd", last_cmd, 1);
        chk("mid_rearm_seq", seq_error, 1);
        chk("mid_rearm_errcnt", err_count, 1);

        // err_clear coinciding with a bad-code qualify.
        sig_in = 5'b11001;
        repeat (18) tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("clrbad_pulse", bad_code, 1);
        chk("clrbad_errcnt", err_count, 1);
        chk("clrbad_seq", seq_error, 0);
        tick();
        chk("clrbad_pulse_end", bad_code, 0);
        sig_in = 5'b0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
